// File: rtl/cam_ctrl_pkg.sv
// rtl/cam_ctrl_pkg.sv - shared types and constants for the CAM insert/delete controller
// Purpose: FSM state encoding, request op encoding and default geometry.
package cam_ctrl_pkg;

    localparam int CAM_ENTRIES = 32;
    localparam int CAM_IDX_W   = 5;
    localparam int CAM_DATA_W  = 32;

    localparam logic OP_INSERT = 1'b0;
    localparam logic OP_DELETE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SRCH,
        ST_WAIT,
        ST_WRITE,
        ST_RESP
    } ctrl_state_e;

endpackage

// File: rtl/cam_insert_ctrl_if.sv
// rtl/cam_insert_ctrl_if.sv - request/response and CAM port bundle for cam_insert_ctrl
// Purpose: groups the client request/response channels and the CAM search/write ports.
// Modports:
//   master - client + CAM side: drives req_*, rsp_ready, cam_search_valid/index
//   slave  - controller side: drives req_ready, rsp_*, cam_write_*, cam_search_enable/data, full
interface cam_insert_ctrl_if
    import cam_ctrl_pkg::*;
#(
    parameter int IDX_W  = CAM_IDX_W,
    parameter int DATA_W = CAM_DATA_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_op;
    logic [DATA_W-1:0] req_data;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_hit;
    logic              rsp_evict;
    logic [IDX_W-1:0]  rsp_index;

    logic              cam_write_enable;
    logic [IDX_W-1:0]  cam_write_index;
    logic [DATA_W-1:0] cam_write_data;
    logic              cam_search_enable;
    logic [DATA_W-1:0] cam_search_data;
    logic              cam_search_valid;
    logic [IDX_W-1:0]  cam_search_index;

    logic              full;

    modport master (
        output req_valid, req_op, req_data, rsp_ready, cam_search_valid, cam_search_index,
        input  req_ready, rsp_valid, rsp_hit, rsp_evict, rsp_index,
        input  cam_write_enable, cam_write_index, cam_write_data,
        input  cam_search_enable, cam_search_data, full
    );

    modport slave (
        input  req_valid, req_op, req_data, rsp_ready, cam_search_valid, cam_search_index,
        output req_ready, rsp_valid, rsp_hit, rsp_evict, rsp_index,
        output cam_write_enable, cam_write_index, cam_write_data,
        output cam_search_enable, cam_search_data, full
    );

endinterface

// File: rtl/cam_free_prienc.sv
// rtl/cam_free_prienc.sv - lowest-clear-bit encoder over the occupancy bitmap
// Ports:
//   bitmap_i   - occupancy bitmap, 1 = entry in use
//   free_idx_o - lowest index whose bit is clear (0 when none is clear)
//   any_free_o - at least one bit is clear
module cam_free_prienc
    import cam_ctrl_pkg::*;
#(
    parameter int ENTRIES = CAM_ENTRIES,
    parameter int IDX_W   = CAM_IDX_W
) (
    input  logic [ENTRIES-1:0] bitmap_i,
    output logic [IDX_W-1:0]   free_idx_o,
    output logic               any_free_o
);

    // Scanning downward lets the lowest clear bit overwrite any higher one.
    always_comb begin
        free_idx_o = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!bitmap_i[i]) begin
                free_idx_o = IDX_W'(i);
            end
        end
    end

    assign any_free_o = ~&bitmap_i;

endmodule

// File: rtl/cam_insert_ctrl.sv
// rtl/cam_insert_ctrl.sv - sequences single insert/delete requests into CAM search/write operations
// Ports:
//   clk_i, rst_i - clock, synchronous active-high reset
//   bus          - slave side of cam_insert_ctrl_if (request, response, CAM ports, full)
//   stat_*_o     - 16-bit saturating hit/miss/evict counters, only with CAM_INSERT_STATS_EN
// Occupancy is tracked in a bitmap; a CAM match is only a hit when its bitmap bit is set.
// Free slots are taken lowest-index-first; a full table evicts round-robin.
module cam_insert_ctrl
    import cam_ctrl_pkg::*;
#(
    parameter int ENTRIES = CAM_ENTRIES,
    parameter int IDX_W   = CAM_IDX_W,
    parameter int DATA_W  = CAM_DATA_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    cam_insert_ctrl_if.slave     bus
`ifdef CAM_INSERT_STATS_EN
    ,
    output logic [15:0]          stat_hit_o,
    output logic [15:0]          stat_miss_o,
    output logic [15:0]          stat_evict_o
`endif
);

    ctrl_state_e        state_q, state_d;
    logic               op_q, op_d;
    logic [DATA_W-1:0]  key_q, key_d;
    logic [ENTRIES-1:0] bitmap_q, bitmap_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               full_q, full_d;
    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_hit_q, rsp_hit_d;
    logic               rsp_evict_q, rsp_evict_d;
    logic [IDX_W-1:0]   rsp_index_q, rsp_index_d;
    logic               wr_en_q, wr_en_d;
    logic               srch_en_q, srch_en_d;

    logic [IDX_W-1:0]   free_idx;
    logic               any_free;
    logic               true_hit;

    cam_free_prienc #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_free_prienc (
        .bitmap_i   (bitmap_q),
        .free_idx_o (free_idx),
        .any_free_o (any_free)
    );

    // A CAM match on an unoccupied slot is stale data left behind by a delete.
    assign true_hit = bus.cam_search_valid && bitmap_q[bus.cam_search_index];

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        key_d       = key_q;
        bitmap_d    = bitmap_q;
        rr_ptr_d    = rr_ptr_q;
        full_d      = &bitmap_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_evict_d = rsp_evict_q;
        rsp_index_d = rsp_index_q;
        wr_en_d     = 1'b0;
        srch_en_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (bus.req_valid && req_ready_q) begin
                    op_d        = bus.req_op;
                    key_d       = bus.req_data;
                    req_ready_d = 1'b0;
                    srch_en_d   = 1'b1;
                    state_d     = ST_SRCH;
                end
            end
            ST_SRCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                rsp_hit_d   = 1'b0;
                rsp_evict_d = 1'b0;
                rsp_index_d = '0;
                if (op_q == OP_INSERT) begin
                    if (true_hit) begin
                        rsp_hit_d   = 1'b1;
                        rsp_index_d = bus.cam_search_index;
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end else begin
                        wr_en_d = 1'b1;
                        state_d = ST_WRITE;
                        if (bus.cam_search_valid) begin
                            rsp_index_d = bus.cam_search_index;
                        end else if (any_free) begin
                            rsp_index_d = free_idx;
                        end else begin
                            rsp_index_d = rr_ptr_q;
                            rsp_evict_d = 1'b1;
                            rr_ptr_d    = rr_ptr_q + 1'b1;
                        end
                    end
                end else begin
                    if (true_hit) begin
                        bitmap_d[bus.cam_search_index] = 1'b0;
                        rsp_hit_d   = 1'b1;
                        rsp_index_d = bus.cam_search_index;
                    end
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_WRITE: begin
                bitmap_d[rsp_index_q] = 1'b1;
                rsp_valid_d           = 1'b1;
                state_d               = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            op_q        <= 1'b0;
            key_q       <= '0;
            bitmap_q    <= '0;
            rr_ptr_q    <= '0;
            full_q      <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_evict_q <= 1'b0;
            rsp_index_q <= '0;
            wr_en_q     <= 1'b0;
            srch_en_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            key_q       <= key_d;
            bitmap_q    <= bitmap_d;
            rr_ptr_q    <= rr_ptr_d;
            full_q      <= full_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_evict_q <= rsp_evict_d;
            rsp_index_q <= rsp_index_d;
            wr_en_q     <= wr_en_d;
            srch_en_q   <= srch_en_d;
        end
    end

    assign bus.req_ready         = req_ready_q;
    assign bus.rsp_valid         = rsp_valid_q;
    assign bus.rsp_hit           = rsp_hit_q;
    assign bus.rsp_evict         = rsp_evict_q;
    assign bus.rsp_index         = rsp_index_q;
    assign bus.cam_write_enable  = wr_en_q;
    assign bus.cam_write_index   = rsp_index_q;
    assign bus.cam_write_data    = key_q;
    assign bus.cam_search_enable = srch_en_q;
    assign bus.cam_search_data   = key_q;
    assign bus.full              = full_q;

`ifdef CAM_INSERT_STATS_EN
    logic        resp_entry;
    logic [15:0] stat_hit_q, stat_hit_d;
    logic [15:0] stat_miss_q, stat_miss_d;
    logic [15:0] stat_evict_q, stat_evict_d;

    assign resp_entry = (state_d == ST_RESP) && (state_q != ST_RESP);

    always_comb begin
        stat_hit_d   = stat_hit_q;
        stat_miss_d  = stat_miss_q;
        stat_evict_d = stat_evict_q;
        if (resp_entry) begin
            if (rsp_hit_d && stat_hit_q != 16'hFFFF) begin
                stat_hit_d = stat_hit_q + 16'd1;
            end
            if (!rsp_hit_d && stat_miss_q != 16'hFFFF) begin
                stat_miss_d = stat_miss_q + 16'd1;
            end
            if (rsp_evict_d && stat_evict_q != 16'hFFFF) begin
                stat_evict_d = stat_evict_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_hit_q   <= '0;
            stat_miss_q  <= '0;
            stat_evict_q <= '0;
        end else begin
            stat_hit_q   <= stat_hit_d;
            stat_miss_q  <= stat_miss_d;
            stat_evict_q <= stat_evict_d;
        end
    end

    assign stat_hit_o   = stat_hit_q;
    assign stat_miss_o  = stat_miss_q;
    assign stat_evict_o = stat_evict_q;
`endif

endmodule

// File: tb/tb_cam_insert_ctrl.sv
// tb/tb_cam_insert_ctrl.sv - directed self-checking bench for cam_insert_ctrl with a behavioural CAM
module tb_cam_insert_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    cam_insert_ctrl_if #(.IDX_W(5), .DATA_W(32)) bus ();

`ifdef CAM_INSERT_STATS_EN
    logic [15:0] stat_hit, stat_miss, stat_evict;
`endif

    cam_insert_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
`ifdef CAM_INSERT_STATS_EN
        ,
        .stat_hit_o   (stat_hit),
        .stat_miss_o  (stat_miss),
        .stat_evict_o (stat_evict)
`endif
    );

    // Behavioural 32-entry CAM: search result one cycle after enable, lowest matching index wins.
    logic [31:0] cam_mem [32];
    logic [31:0] cam_vld = '0;
    logic        m_hit;
    logic [4:0]  m_idx;

    always_comb begin
        m_hit = 1'b0;
        m_idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (cam_vld[i] && cam_mem[i] == bus.cam_search_data) begin
                m_hit = 1'b1;
                m_idx = 5'(i);
            end
        end
    end

    always @(posedge clk) begin
        if (bus.cam_write_enable) begin
            cam_mem[bus.cam_write_index] <= bus.cam_write_data;
            cam_vld[bus.cam_write_index] <= 1'b1;
        end
        bus.cam_search_valid <= bus.cam_search_enable && m_hit;
        bus.cam_search_index <= m_idx;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issues one request at posedge+1 and checks latency, response fields and CAM writes.
    // Leaves the response consumed only if rsp_ready is high.
    task automatic txn(input string tag, input logic op, input logic [31:0] key,
                       input int exp_lat, input logic exp_hit, input logic exp_evict,
                       input logic [4:0] exp_idx);
        int          lat;
        int          nwr;
        logic [4:0]  wr_idx;
        logic [31:0] wr_data;
        wr_idx  = '0;
        wr_data = '0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_data  = key;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        nwr = 0;
        while (!bus.rsp_valid && lat < 20) begin
            if (bus.cam_write_enable) begin
                nwr++;
                wr_idx  = bus.cam_write_index;
                wr_data = bus.cam_write_data;
            end
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_lat"},   32'(lat), 32'(exp_lat));
        check_eq({tag, "_hit"},   32'(bus.rsp_hit), 32'(exp_hit));
        check_eq({tag, "_evict"}, 32'(bus.rsp_evict), 32'(exp_evict));
        check_eq({tag, "_index"}, 32'(bus.rsp_index), 32'(exp_idx));
        check_eq({tag, "_nwr"},   32'(nwr), (exp_lat == 4) ? 32'd1 : 32'd0);
        if (exp_lat == 4) begin
            check_eq({tag, "_wr_idx"},  32'(wr_idx), 32'(exp_idx));
            check_eq({tag, "_wr_data"}, wr_data, key);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 1'b0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("rst_wr_en",     32'(bus.cam_write_enable), 32'd0);
        check_eq("rst_srch_en",   32'(bus.cam_search_enable), 32'd0);
        check_eq("rst_full",      32'(bus.full), 32'd0);
        check_eq("rst_index",     32'(bus.rsp_index), 32'd0);

        txn("ins_first", 1'b0, 32'hDEADBEEF, 4, 1'b0, 1'b0, 5'd0);
        txn("ins_again", 1'b0, 32'hDEADBEEF, 3, 1'b1, 1'b0, 5'd0);

        // Restart with an empty bitmap so keys 1..32 land on indices 0..31.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            txn("fill", 1'b0, 32'(k), 4, 1'b0, 1'b0, 5'(k - 1));
        end
        check_eq("full_before_evict", 32'(bus.full), 32'd1);
        txn("evict0", 1'b0, 32'h100, 4, 1'b0, 1'b1, 5'd0);
        txn("evict1", 1'b0, 32'h101, 4, 1'b0, 1'b1, 5'd1);

        txn("del5",       1'b1, 32'd5, 3, 1'b1, 1'b0, 5'd4);
        check_eq("full_after_del", 32'(bus.full), 32'd0);
        txn("del5_again", 1'b1, 32'd5, 3, 1'b0, 1'b0, 5'd0);
        txn("ins5_stale", 1'b0, 32'd5, 4, 1'b0, 1'b0, 5'd4);
        check_eq("full_after_reins", 32'(bus.full), 32'd1);

        bus.rsp_ready = 1'b0;
        txn("hold", 1'b0, 32'h200, 4, 1'b0, 1'b1, 5'd2);
        for (int c = 0; c < 9; c++) begin
            check_eq("hold_valid", 32'(bus.rsp_valid), 32'd1);
            check_eq("hold_index", 32'(bus.rsp_index), 32'd2);
            check_eq("hold_evict", 32'(bus.rsp_evict), 32'd1);
            check_eq("hold_ready", 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("hold_release_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("hold_release_ready", 32'(bus.req_ready), 32'd1);

        // Abort an evicting insert while it sits in WAIT.
        bus.req_valid = 1'b1;
        bus.req_op    = 1'b0;
        bus.req_data  = 32'h400;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("abort_rsp_hit",   32'(bus.rsp_hit), 32'd0);
        check_eq("abort_rsp_evict", 32'(bus.rsp_evict), 32'd0);
        check_eq("abort_rsp_index", 32'(bus.rsp_index), 32'd0);
        check_eq("abort_wr_en",     32'(bus.cam_write_enable), 32'd0);
        check_eq("abort_srch_en",   32'(bus.cam_search_enable), 32'd0);
        check_eq("abort_full",      32'(bus.full), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check_eq("post_abort_wr_en",  32'(bus.cam_write_enable), 32'd0);
            check_eq("post_abort_rsp",    32'(bus.rsp_valid), 32'd0);
            check_eq("post_abort_ready",  32'(bus.req_ready), 32'd1);
            @(posedge clk); #1;
        end
        txn("after_abort", 1'b0, 32'h500, 4, 1'b0, 1'b0, 5'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
